// File: rtl/dual_update.sv
// ADMM dual update: y += u - z over the input horizon, then g += x - v over the state horizon,
// written back in place while tracking max|u - z| and max|x - v| as primal residuals.
module dual_update #(
  parameter int STATE_DIM  = 12,
  parameter int INPUT_DIM  = 4,
  parameter int HORIZON    = 30,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           active_horizon,
  output logic [ADDR_WIDTH-1:0] u_rdaddress,
  output logic [ADDR_WIDTH-1:0] z_rdaddress,
  output logic [ADDR_WIDTH-1:0] y_rdaddress,
  input  logic [DATA_WIDTH-1:0] u_data_out,
  input  logic [DATA_WIDTH-1:0] z_data_out,
  input  logic [DATA_WIDTH-1:0] y_data_out,
  output logic [ADDR_WIDTH-1:0] x_rdaddress,
  output logic [ADDR_WIDTH-1:0] v_rdaddress,
  output logic [ADDR_WIDTH-1:0] g_rdaddress,
  input  logic [DATA_WIDTH-1:0] x_data_out,
  input  logic [DATA_WIDTH-1:0] v_data_out,
  input  logic [DATA_WIDTH-1:0] g_data_out,
  output logic [ADDR_WIDTH-1:0] y_wraddress,
  output logic [DATA_WIDTH-1:0] y_data_in,
  output logic                  y_wren,
  output logic [ADDR_WIDTH-1:0] g_wraddress,
  output logic [DATA_WIDTH-1:0] g_data_in,
  output logic                  g_wren,
  output logic [DATA_WIDTH-1:0] prim_res_u,
  output logic [DATA_WIDTH-1:0] prim_res_x,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = ADDR_WIDTH + 1;

  // The fixed-point format does not change add/subtract, but it must leave an integer bit.
  if (FRAC_BITS >= DATA_WIDTH || STATE_DIM * HORIZON > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("dual_update: FRAC_BITS or ADDR_WIDTH inconsistent with DATA_WIDTH/STATE_DIM/HORIZON");
  end

  typedef enum logic [1:0] {IDLE, DUAL_Y, DUAL_G, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         n_y, n_g, t;
  logic [ADDR_WIDTH-1:0] u_addr, x_addr;

  assign u_rdaddress = u_addr;
  assign z_rdaddress = u_addr;
  assign y_rdaddress = u_addr;
  assign x_rdaddress = x_addr;
  assign v_rdaddress = x_addr;
  assign g_rdaddress = x_addr;

  function automatic logic [DATA_WIDTH-1:0] sat_sum(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b,
                                                    input logic [DATA_WIDTH-1:0] c);
    logic [DATA_WIDTH+1:0] s;
    s = {{2{a[DATA_WIDTH-1]}}, a} + {{2{b[DATA_WIDTH-1]}}, b} - {{2{c[DATA_WIDTH-1]}}, c};
    if (s[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b000 || s[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b111)
      return s[DATA_WIDTH-1:0];
    else if (s[DATA_WIDTH+1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] c);
    logic [DATA_WIDTH:0] d;
    d = {a[DATA_WIDTH-1], a} - {c[DATA_WIDTH-1], c};
    if (d[DATA_WIDTH]) d = -d;
    // |d| can reach 2^DW - 1; anything past the signed max pins to it
    if (d[DATA_WIDTH] || d[DATA_WIDTH-1])
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      return d[DATA_WIDTH-1:0];
  endfunction

  logic [31:0]           neff;
  logic [CW-1:0]         ny_next, ng_next, n_cur, t_inc;
  logic                  in_y, wr_slot, last;
  logic [DATA_WIDTH-1:0] op_a, op_b, op_c, sum_sat, res_mag;

  always_comb begin
    neff = active_horizon;
    if (active_horizon == 32'd0)
      neff = 32'd1;
    else if (active_horizon > 32'(HORIZON))
      neff = 32'(HORIZON);
  end

  assign ny_next = CW'(32'(INPUT_DIM) * (neff - 32'd1));
  assign ng_next = CW'(32'(STATE_DIM) * neff);

  assign in_y    = (state == DUAL_Y);
  assign op_a    = in_y ? u_data_out : x_data_out;
  assign op_b    = in_y ? y_data_out : g_data_out;
  assign op_c    = in_y ? z_data_out : v_data_out;
  assign sum_sat = sat_sum(op_a, op_b, op_c);
  assign res_mag = abs_diff(op_a, op_c);

  // t counts cycles since phase entry; read data for element t-2 arrives while 2 <= t <= n+1
  assign n_cur   = in_y ? n_y : n_g;
  assign t_inc   = t + CW'(1);
  assign wr_slot = (t >= CW'(2)) && (t <= n_cur + CW'(1));
  assign last    = (t == n_cur + CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_y         <= '0;
      n_g         <= '0;
      t           <= '0;
      u_addr      <= '0;
      x_addr      <= '0;
      y_wraddress <= '0;
      y_data_in   <= '0;
      y_wren      <= 1'b0;
      g_wraddress <= '0;
      g_data_in   <= '0;
      g_wren      <= 1'b0;
      prim_res_u  <= '0;
      prim_res_x  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      y_wren <= 1'b0;
      g_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_y        <= ny_next;
            n_g        <= ng_next;
            t          <= '0;
            prim_res_u <= '0;
            prim_res_x <= '0;
            busy       <= 1'b1;
            if (ny_next != '0) begin
              state  <= DUAL_Y;
              u_addr <= '0;
            end else begin
              state  <= DUAL_G;
              x_addr <= '0;
            end
          end
        end
        DUAL_Y: begin
          t <= t_inc;
          if (t_inc < n_y) u_addr <= ADDR_WIDTH'(t_inc);
          if (wr_slot) begin
            y_wren      <= 1'b1;
            y_wraddress <= ADDR_WIDTH'(t - CW'(2));
            y_data_in   <= sum_sat;
            if (res_mag > prim_res_u) prim_res_u <= res_mag;
          end
          if (last) begin
            state  <= DUAL_G;
            t      <= '0;
            x_addr <= '0;
          end
        end
        DUAL_G: begin
          t <= t_inc;
          if (t_inc < n_g) x_addr <= ADDR_WIDTH'(t_inc);
          if (wr_slot) begin
            g_wren      <= 1'b1;
            g_wraddress <= ADDR_WIDTH'(t - CW'(2));
            g_data_in   <= sum_sat;
            if (res_mag > prim_res_x) prim_res_x <= res_mag;
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_update.sv
// Bench for dual_update: 2-cycle-latency memory models, an arithmetic reference, write logs.
module tb_dual_update;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] active_horizon = 32'd0;
  logic [8:0]  u_rdaddress, z_rdaddress, y_rdaddress, x_rdaddress, v_rdaddress, g_rdaddress;
  logic [15:0] u_data_out, z_data_out, y_data_out, x_data_out, v_data_out, g_data_out;
  logic [8:0]  y_wraddress, g_wraddress;
  logic [15:0] y_data_in, g_data_in, prim_res_u, prim_res_x;
  logic        y_wren, g_wren, busy, done;

  dual_update dut (
    .clk(clk), .rst_n(rst_n), .start(start), .active_horizon(active_horizon),
    .u_rdaddress(u_rdaddress), .z_rdaddress(z_rdaddress), .y_rdaddress(y_rdaddress),
    .u_data_out(u_data_out), .z_data_out(z_data_out), .y_data_out(y_data_out),
    .x_rdaddress(x_rdaddress), .v_rdaddress(v_rdaddress), .g_rdaddress(g_rdaddress),
    .x_data_out(x_data_out), .v_data_out(v_data_out), .g_data_out(g_data_out),
    .y_wraddress(y_wraddress), .y_data_in(y_data_in), .y_wren(y_wren),
    .g_wraddress(g_wraddress), .g_data_in(g_data_in), .g_wren(g_wren),
    .prim_res_u(prim_res_u), .prim_res_x(prim_res_x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] um[512], zm[512], ym[512], xm[512], vm[512], gm[512];
  logic [15:0] u_p, z_p, y_p, x_p, v_p, g_p;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    u_p <= um[u_rdaddress]; u_data_out <= u_p;
    z_p <= zm[z_rdaddress]; z_data_out <= z_p;
    y_p <= ym[y_rdaddress]; y_data_out <= y_p;
    x_p <= xm[x_rdaddress]; x_data_out <= x_p;
    v_p <= vm[v_rdaddress]; v_data_out <= v_p;
    g_p <= gm[g_rdaddress]; g_data_out <= g_p;
    if (y_wren) ym[y_wraddress] <= y_data_in;
    if (g_wren) gm[g_wraddress] <= g_data_in;
  end

  typedef struct { int addr; logic [15:0] dat; int cyc; } wr_t;
  wr_t ylog[$], glog[$];

  always @(negedge clk) begin
    if (y_wren) ylog.push_back('{addr: int'(y_wraddress), dat: y_data_in, cyc: cyc});
    if (g_wren) glog.push_back('{addr: int'(g_wraddress), dat: g_data_in, cyc: cyc});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) - int'($signed(c));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic int ref_res(input logic [15:0] a, input logic [15:0] c);
    int d;
    d = int'($signed(a)) - int'($signed(c));
    if (d < 0) d = -d;
    return (d > 32767) ? 32767 : d;
  endfunction

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {28'd0, y_wren, g_wren, busy, done}, 32'd0);
    chk({tag, "_res"}, {prim_res_u, prim_res_x}, 32'd0);
    chk({tag, "_rdaddr"}, {5'd0, u_rdaddress, x_rdaddress, z_rdaddress}, 32'd0);
    chk({tag, "_wr"}, {14'd0, y_wraddress, g_wraddress}, 32'd0);
    chk({tag, "_wdat"}, {y_data_in, g_data_in}, 32'd0);
  endtask

  task automatic fill_const(input logic [15:0] u, input logic [15:0] z, input logic [15:0] y,
                            input logic [15:0] x, input logic [15:0] v, input logic [15:0] g);
    for (int i = 0; i < 512; i++) begin
      um[i] = u; zm[i] = z; ym[i] = y; xm[i] = x; vm[i] = v; gm[i] = g;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) begin
      um[i] = 16'($urandom); zm[i] = 16'($urandom); ym[i] = 16'($urandom);
      xm[i] = 16'($urandom); vm[i] = 16'($urandom); gm[i] = 16'($urandom);
    end
  endtask

  // One full run; expectations come from the memory contents before the run starts.
  task automatic run(input string tag, input logic [31:0] ah, input int pulse_at, input bit hold);
    int neff, ny, ng, exp_done, base, t_done, g_first, eru, erx;
    logic [15:0] ey[512], eg[512];
    neff = (ah == 0) ? 1 : ((ah > 30) ? 30 : int'(ah));
    ny = 4 * (neff - 1);
    ng = 12 * neff;
    exp_done = (ny > 0) ? (1 + (ny + 3) + (ng + 3)) : (1 + ng + 3);
    g_first = ((ny > 0) ? (1 + ny + 3) : 1) + 3;
    eru = 0; erx = 0;
    for (int e = 0; e < ny; e++) begin
      ey[e] = ref_sum(um[e], ym[e], zm[e]);
      if (ref_res(um[e], zm[e]) > eru) eru = ref_res(um[e], zm[e]);
    end
    for (int e = 0; e < ng; e++) begin
      eg[e] = ref_sum(xm[e], gm[e], vm[e]);
      if (ref_res(xm[e], vm[e]) > erx) erx = ref_res(xm[e], vm[e]);
    end
    ylog.delete(); glog.delete();
    @(negedge clk);
    active_horizon = ah;
    start = 1'b1;
    @(posedge clk); #1;
    base = cyc;
    if (!hold) start = 1'b0;
    active_horizon = $urandom;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    t_done = 0;
    for (int k = 1; k <= 700; k++) begin
      if (done) begin t_done = k; break; end
      if (!hold) start = (pulse_at != 0 && k == pulse_at);
      @(posedge clk); #1;
    end
    chk({tag, "_done_cycle"}, t_done, exp_done);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_y_count"}, ylog.size(), ny);
    chk({tag, "_g_count"}, glog.size(), ng);
    foreach (ylog[i]) begin
      if (i < ny) begin
        chk({tag, "_y_addr"}, ylog[i].addr, i);
        chk({tag, "_y_data"}, {16'd0, ylog[i].dat}, {16'd0, ey[i]});
        chk({tag, "_y_cycle"}, ylog[i].cyc - base + 1, 4 + i);
      end
    end
    foreach (glog[i]) begin
      if (i < ng) begin
        chk({tag, "_g_addr"}, glog[i].addr, i);
        chk({tag, "_g_data"}, {16'd0, glog[i].dat}, {16'd0, eg[i]});
        chk({tag, "_g_cycle"}, glog[i].cyc - base + 1, g_first + i);
      end
    end
    chk({tag, "_res_u"}, {16'd0, prim_res_u}, eru);
    chk({tag, "_res_x"}, {16'd0, prim_res_x}, erx);
    if (hold) begin
      repeat (5) @(posedge clk);
      #1;
      chk({tag, "_hold_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_hold_no_restart"}, ylog.size() + glog.size(), ny + ng);
      chk({tag, "_hold_res_u"}, {16'd0, prim_res_u}, eru);
      start = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int found, n0;
    #2;
    check_reset_outs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    fill_const(16'h0100, 16'h0080, 16'h0010, 16'h0200, 16'h0180, 16'hFFF0);
    run("nominal", 32'd2, 0, 1'b0);
    chk("nominal_y3", {16'd0, ym[3]}, 32'h0090);
    chk("nominal_y4_untouched", {16'd0, ym[4]}, 32'h0010);
    chk("nominal_g23", {16'd0, gm[23]}, 32'h0070);
    chk("nominal_res", {prim_res_u, prim_res_x}, 32'h0080_0080);

    fill_rand();
    um[0] = 16'h0200; zm[0] = 16'h0000; ym[0] = 16'h7F00;
    um[1] = 16'hFE00; zm[1] = 16'h0100; ym[1] = 16'h8100;
    um[2] = 16'h8000; zm[2] = 16'h7FFF;
    run("sat", 32'd2, 0, 1'b0);
    chk("sat_pos", {16'd0, ym[0]}, 32'h7FFF);
    chk("sat_neg", {16'd0, ym[1]}, 32'h8000);
    chk("sat_res", {16'd0, prim_res_u}, 32'h7FFF);

    fill_rand();
    run("n1", 32'd1, 0, 1'b0);
    run("n0", 32'd0, 0, 1'b0);
    run("n100", 32'd100, 0, 1'b0);
    run("nrand", 32'($urandom_range(3, 29)), 0, 1'b0);

    fill_rand();
    run("pulse_in_g", 32'd5, 30, 1'b0);
    run("hold", 32'd3, 0, 1'b1);
    fill_const(16'h0123, 16'h0123, 16'h0042, 16'hF000, 16'hF000, 16'h0001);
    run("restart_clear", 32'd2, 0, 1'b0);

    fill_rand();
    @(negedge clk);
    active_horizon = 32'd30;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (y_wren && y_wraddress == 9'd50) begin found = 1; break; end
    end
    chk("midrst_reached_e50", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n0 = ylog.size() + glog.size();
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_no_writes", ylog.size() + glog.size(), n0);
    chk("midrst_idle", {30'd0, busy, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
